mem_dump_reader: RTL and testbench

Read-back engine for the RISC-V core's data memory port. On a start request it walks a range of word addresses, sequences the data-memory read strobe with the required hold time, and streams each captured word out over a valid/ready interface. It sits between the core's data-memory read port (address / read strobe / read data) and any consumer such as a debug UART or a self-checking bench. It is the reading counterpart of the program-load path that writes the instruction memory.

---
 rtl/mem_dump_reader.sv | 170 +++++++++++++++++
 tb/tb_mem_dump_reader.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_reader.sv
`timescale 1ns/1ps
// mem_dump_reader: walks a range of data-memory word addresses, strobes the
// read port with a fixed hold time and streams each captured word out over a
// valid/ready interface.
// Optional feature: define DUMP_CHECKSUM_EN to build the running checksum;
// otherwise the checksum port is tied to zero.
module mem_dump_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 3,
    parameter int STEP   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] checksum
);

    localparam int                HOLD_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] STEP_A    = ADDR_W'(STEP);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          rem_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                rd_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic [DATA_W-1:0]   odata_q;
    logic [ADDR_W-1:0]   oaddr_q;

    // Next word address wraps naturally modulo 2^ADDR_W.
    logic [ADDR_W-1:0]   addr_inc_d;
    logic                start_acc_d;
    logic                handshake_d;

    assign addr_inc_d  = addr_q + STEP_A;
    assign start_acc_d = (state_q == IDLE) && start;
    // abort wins over a handshake in the same cycle: that word is not transferred.
    assign handshake_d = (state_q == SEND) && out_ready && !abort;

    // Dump sequencer; every output is registered and set on the transition into its state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            hold_q  <= '0;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            odata_q <= '0;
            oaddr_q <= '0;
        end else if (abort && (state_q != IDLE)) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        addr_q <= base_addr;
                        rem_q  <= word_count;
                        if (word_count == 8'd0) begin
                            // Empty dump: straight to completion, no memory access.
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    hold_q  <= '0;
                    rd_q    <= 1'b1;
                    state_q <= READ;
                end
                READ: begin
                    if (hold_q == HOLD_LAST) begin
                        rd_q    <= 1'b0;
                        state_q <= CAPTURE;
                    end else begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                CAPTURE: begin
                    odata_q <= mem_rdata;
                    oaddr_q <= addr_q;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        rem_q   <= rem_q - 8'd1;
                        addr_q  <= addr_inc_d;
                        if (rem_q == 8'd1) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= SETUP;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    // Running sum of transferred words, restarted by each accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else if (start_acc_d) begin
            sum_q <= '0;
        end else if (handshake_d) begin
            sum_q <= sum_q + odata_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign out_valid = valid_q;
    assign out_data  = odata_q;
    assign out_addr  = oaddr_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
`timescale 1ns/1ps
// Scoreboard bench for mem_dump_reader: a memory model answers reads, the
// expected word stream is queued when a dump is issued, and a monitor checks
// every handshake, done pulse and read-strobe window.
module tb_mem_dump_reader;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 3;
    localparam int STEP   = 4;

    logic              clock;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] checksum;

    mem_dump_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STEP(STEP)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count), .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .checksum(checksum)
    );

    logic [DATA_W-1:0] mem [0:255];
    assign mem_rdata = mem[mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [DATA_W-1:0] exp_data_q [$];
    logic [DATA_W-1:0] exp_done_q [$];
    int                done_seen  = 0;
    int                ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference model: word i of a dump lives at (base + i*STEP) mod 256.
    task automatic push_dump(input int base, input int count);
        logic [DATA_W-1:0] sum;
        int a;
        sum = '0;
        for (int i = 0; i < count; i++) begin
            a = (base + i * STEP) % 256;
            exp_addr_q.push_back(ADDR_W'(a));
            exp_data_q.push_back(mem[a]);
            sum = sum + mem[a];
        end
`ifdef DUMP_CHECKSUM_EN
        exp_done_q.push_back(sum);
`else
        exp_done_q.push_back('0);
`endif
    endtask

    task automatic flush_expect();
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_done_q.delete();
    endtask

    // Returns just after the edge that accepts start.
    task automatic pulse_start(input int base, input int count);
        @(posedge clock);
        #1;
        start      = 1'b1;
        base_addr  = ADDR_W'(base);
        word_count = 8'(count);
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && done_seen < target; i++) @(negedge clock);
        if (done_seen < target) begin
            flag_fail("done_timeout");
            @(posedge clock);
            #1 reset = 1'b1;
            @(posedge clock);
            #1 reset = 1'b0;
            flush_expect();
            done_seen = target;
        end
        @(negedge clock);
        check("leftover_words", 64'(exp_addr_q.size()), 64'd0);
    endtask

    task automatic run_dump(input int base, input int count);
        int target;
        push_dump(base, count);
        target = done_seen + 1;
        pulse_start(base, count);
        wait_done(target);
    endtask

    // Consumer: 0 always ready, 1 toggling, 2 random, 3 never ready.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: handshakes, stall stability, done pulses, read-strobe window.
    initial begin
        logic              stall;
        logic [DATA_W-1:0] held_data;
        logic [ADDR_W-1:0] held_addr;
        int                rd_len;
        logic [ADDR_W-1:0] rd_addr;
        stall  = 1'b0;
        rd_len = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall  = 1'b0;
                rd_len = 0;
            end else begin
                if (out_valid) begin
                    if (stall) begin
                        check("stall_data_stable", 64'(out_data), 64'(held_data));
                        check("stall_addr_stable", 64'(out_addr), 64'(held_addr));
                    end
                    if (out_ready && !abort) begin
                        if (exp_addr_q.size() == 0) begin
                            flag_fail("unexpected_word");
                        end else begin
                            check("out_addr", 64'(out_addr), 64'(exp_addr_q.pop_front()));
                            check("out_data", 64'(out_data), 64'(exp_data_q.pop_front()));
                        end
                    end
                    stall     = !out_ready;
                    held_data = out_data;
                    held_addr = out_addr;
                end else begin
                    stall = 1'b0;
                end
                if (done) begin
                    done_seen++;
                    if (exp_done_q.size() == 0) flag_fail("unexpected_done");
                    else check("checksum_at_done", 64'(checksum), 64'(exp_done_q.pop_front()));
                end
                if (mem_rd) begin
                    if (rd_len > 0) check("addr_stable_while_rd", 64'(mem_addr), 64'(rd_addr));
                    rd_addr = mem_addr;
                    rd_len++;
                    if (abort) rd_len = 0;
                end else if (rd_len > 0) begin
                    check("rd_strobe_length", 64'(rd_len), 64'(RD_LAT));
                    rd_len = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Single word with exact cycle timing from the accepting edge.
        ready_mode = 0;
        mem[8] = 32'd21;
        push_dump(8, 1);
        target = done_seen + 1;
        pulse_start(8, 1);
        for (int k = 1; k <= RD_LAT + 4; k++) begin
            @(negedge clock);
            check("t1_mem_rd", 64'(mem_rd), 64'((k >= 2) && (k <= RD_LAT + 1)));
            if (mem_rd) check("t1_mem_addr", 64'(mem_addr), 64'd8);
            check("t1_out_valid", 64'(out_valid), 64'(k == RD_LAT + 3));
            check("t1_done", 64'(done), 64'(k == RD_LAT + 4));
        end
        wait_done(target);

        // Four words with a toggling consumer.
        mem[0] = 32'd1; mem[4] = 32'd2; mem[8] = 32'd3; mem[12] = 32'd4;
        ready_mode = 1;
        run_dump(0, 4);

        // Address wrap-around.
        ready_mode = 2;
        run_dump(8'hF8, 3);

        // Empty dump: done one cycle after start, no access, never busy.
        ready_mode = 0;
        push_dump(8'h30, 0);
        target = done_seen + 1;
        pulse_start(8'h30, 0);
        @(negedge clock);
        check("c0_done", 64'(done), 64'd1);
        check("c0_busy", 64'(busy), 64'd0);
        check("c0_mem_rd", 64'(mem_rd), 64'd0);
        @(negedge clock);
        check("c0_done_drop", 64'(done), 64'd0);
        check("c0_busy_after", 64'(busy), 64'd0);
        check("c0_mem_rd_after", 64'(mem_rd), 64'd0);
        wait_done(target);

        // Abort during the read of word 2 of 4.
        push_dump(8'h40, 4);
        pulse_start(8'h40, 4);
        n = 0;
        while (n < 200 && !(mem_rd && exp_addr_q.size() == 3)) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) flag_fail("abort_wait_timeout");
        @(posedge clock);
        #1 abort = 1'b1;
        @(posedge clock);
        #1 abort = 1'b0;
        flush_expect();
        @(negedge clock);
        check("abort_mem_rd", 64'(mem_rd), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (10) @(negedge clock);
        check("abort_no_done", 64'(done), 64'd0);
        run_dump(0, 1);

        // start pulsed while busy must be ignored.
        ready_mode = 1;
        push_dump(8'h20, 3);
        target = done_seen + 1;
        pulse_start(8'h20, 3);
        repeat (4) @(posedge clock);
        #1;
        start      = 1'b1;
        base_addr  = 8'h80;
        word_count = 8'd5;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(target);

        // reset while a word waits in SEND.
        ready_mode = 3;
        push_dump(8'h10, 2);
        pulse_start(8'h10, 2);
        n = 0;
        while (n < 100 && !out_valid) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) flag_fail("send_wait_timeout");
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        flush_expect();
        @(negedge clock);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_done", 64'(done), 64'd0);
        check("rs_mem_addr", 64'(mem_addr), 64'd0);
        check("rs_mem_rd", 64'(mem_rd), 64'd0);
        check("rs_out_valid", 64'(out_valid), 64'd0);
        check("rs_out_data", 64'(out_data), 64'd0);
        check("rs_out_addr", 64'(out_addr), 64'd0);
        check("rs_checksum", 64'(checksum), 64'd0);

        // Randomized dumps.
        for (int it = 0; it < 25; it++) begin
            ready_mode = $urandom_range(0, 2);
            run_dump($urandom_range(0, 255), $urandom_range(0, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
